trig_lut_unit: RTL and testbench
================================

# trig_lut_unit

Full-circle sine/cosine unit: accepts an unsigned integer angle in degrees of any magnitude and returns sin or cos as an IEEE-754 double. Internally it does a sequential modulo-360 reduction, a quadrant fold and a 91-entry first-quadrant cosine ROM lookup. It is the parametrised successor of the first-quadrant cosine LUT: wider angles, sin/cos mode, a tag, and valid/ready handshakes. It sits between the angle source and the DFPU result path.

## Interface
- `ANGLE_W`, default 32 (`` `DATA_WIDTH ``): input angle width; must be ≥ 9 (elaboration error otherwise).
- `TAG_W`, default 4: opaque tag carried from input to output.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `in_angle` in ANGLE_W: unsigned angle, degrees.
- `in_sin` in 1: 1 = sine, 0 = cosine.
- `in_tag` in TAG_W: request tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts result.
- `out_data` out 64: IEEE-754 double result.
- `out_tag` out TAG_W: tag of the result.

## Operation
- FSM states: IDLE, REDUCE, LOOKUP, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch angle into the remainder register `rem`, latch mode and tag, set shift `k`=ANGLE_W-9, go to REDUCE.
- REDUCE (restoring modulo), one step per cycle:
  - If `rem` ≥ 360<<k then `rem` -= 360<<k.
  - If k==0 go to LOOKUP, else k--.
  - Compare in ANGLE_W+9 bits so nothing overflows.
  - Result: `rem` = in_angle mod 360, giving r in 0..359.
- LOOKUP:
  - Sine maps to cosine: c = r≥90 ? r-90 : r+270.
  - Cosine uses c = r.
  - Cosine fold:
    - 0..89 → +ROM[c]
    - 90..179 → −ROM[180-c]
    - 180..269 → −ROM[c-180]
    - 270..359 → +ROM[360-c]
  - Register the result into `out_data`/`out_tag`, set `out_valid`, go to DONE.
- Zero rule: a zero magnitude (ROM[90]) always outputs +0.0 (64'h0). The −0.0 encoding is never produced.
- DONE:
  - Hold `out_data`, `out_tag` and `out_valid`=1 stable until `out_ready`.
  - On `out_valid`&&`out_ready`: clear `out_valid`, go to IDLE.
- ROM contents: correctly rounded cos(n°) for n=0..90. Examples:
  - ROM[0]=3FF0000000000000
  - ROM[60]=3FE0000000000000
  - ROM[90]=0
- `in_valid` while not in IDLE is ignored; `in_ready`=0 there. The source must hold its request.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=64'h0, `out_tag`=0, internal registers 0.
- Reset asserted mid-operation (any state) abandons the request. No output is produced for it.
- Latency: request accepted at edge N → `out_valid` high after edge N+ANGLE_W-7 (25 cycles for ANGLE_W=32).
- Latency is independent of angle value and mode.
- Back-to-back throughput: accept at N, result accepted at the earliest edge (N+ANGLE_W-6), IDLE from the following edge, next accept at N+ANGLE_W-5 at earliest.
- `in_ready` is registered from state; there is no combinational path from `out_ready` to `in_ready`.

## Structure
- Shared package / `src/defines.v` holds:
  - constant 360
  - the ROM depth (91)
  - result width 64
  - FSM state encodings
- Sub-module `cos_rom_q1`: combinational 91×64 ROM, 7-bit address, reused by later tan/sec blocks.
- Remainder datapath, fold and sign logic stay in `trig_lut_unit`.

## Test plan
- Reset, then cos angle 0, tag 3 → after 25 cycles `out_data`=3FF0000000000000, `out_tag`=3; reset values checked beforehand.
- Cos angle 90 and cos angle 270 → 0000000000000000 in both cases (never 8000000000000000). Cos angle 180 → BFF0000000000000.
- Sin angle 420 → 3FEBB67AE8584CAA. Sin angle 270 → BFF0000000000000.
- Cos angle FFFFFFFF (reduces to 255) → sign 1, magnitude = ROM[75]. Cos angle 359 → +ROM[1].
- `out_ready` held low 10 cycles → output stable and `in_ready`=0 throughout. Release → next request accepted 2 edges later.
- Reset pulsed during REDUCE → `out_valid` never rises for that request, and a fresh request completes correctly.

Source files
------------

// File: rtl/trig_lut_unit_pkg.sv
// Shared constants, FSM encodings and the first-quadrant cosine table generator.
// Table entries are built at elaboration with wide fixed-point arithmetic.
package trig_lut_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEG_FULL   = 360;
    localparam int ROM_DEPTH  = 91;
    localparam int RES_W      = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int FX_W = 124;
    localparam logic [127:0] PI_FX = 128'h3243F6A8885A308D313198A2E0370734;

    // Correctly rounded double of cos(n deg); ~60 guard bits beyond the ulp.
    function automatic logic [63:0] cos_deg_bits(input int n);
        logic [255:0] prod;
        logic [127:0] x, x2, term, sum, mask;
        logic [53:0]  m;
        logic [63:0]  res;
        int p, e;
        res = 64'h0;
        if (n < ROM_DEPTH - 1) begin
            prod = 256'(PI_FX) * 256'(n);
            prod = prod / 256'd180;
            x    = prod[127:0];
            prod = 256'(x) * 256'(x);
            x2   = prod[FX_W+127:FX_W];
            sum  = 128'd1 << FX_W;
            term = sum;
            for (int k = 1; k <= 30; k++) begin
                prod = 256'(term) * 256'(x2);
                term = prod[FX_W+127:FX_W] / 128'((2 * k - 1) * (2 * k));
                if (k % 2 == 1) sum = sum - term;
                else            sum = sum + term;
            end
            p = 0;
            for (int i = 0; i < 128; i++) begin
                if (sum[i]) p = i;
            end
            e    = p - FX_W + 1023;
            m    = 54'(sum >> (p - 52));
            mask = (128'd1 << (p - 53)) - 128'd1;
            if (sum[p-53] && (m[0] || ((sum & mask) != '0))) m = m + 54'd1;
            if (m[53]) begin
                m = m >> 1;
                e = e + 1;
            end
            res = {1'b0, e[10:0], m[51:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/trig_lut_unit_rom.sv
// cos_rom_q1: combinational 91x64 table of cos(n deg), n = 0..90.
// Shared with the tan/sec blocks.
module cos_rom_q1
    import trig_lut_unit_pkg::*;
(
    input  logic [6:0]       addr_i,
    output logic [RES_W-1:0] data_o
);

    logic [RES_W-1:0] rom [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
        localparam logic [RES_W-1:0] VAL = cos_deg_bits(i);
        assign rom[i] = VAL;
    end

    assign data_o = (addr_i < 7'(ROM_DEPTH)) ? rom[addr_i] : '0;

endmodule

// File: rtl/trig_lut_unit.sv
// Full-circle sin/cos: sequential mod-360 reduction, quadrant fold,
// first-quadrant cosine ROM lookup, IEEE-754 double result.
module trig_lut_unit
    import trig_lut_unit_pkg::*;
#(
    parameter int ANGLE_W = DATA_WIDTH,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ANGLE_W-1:0] in_angle,
    input  logic               in_sin,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int KW = $clog2(ANGLE_W);
    localparam logic [KW-1:0] K_TOP = KW'(ANGLE_W - 9);

    if (ANGLE_W < 9) begin : g_bad_width
        $error("trig_lut_unit: ANGLE_W must be at least 9");
    end

    logic [1:0]         state_q, state_d;
    logic [ANGLE_W-1:0] rem_q, rem_d;
    logic [KW-1:0]      k_q, k_d;
    logic               sin_q, sin_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [RES_W-1:0]   out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_valid_q, out_valid_d;

    logic [ANGLE_W+8:0] div_w, rem_w, diff_w;
    logic [8:0]         r, c;
    logic [6:0]         rom_addr;
    logic [RES_W-1:0]   rom_data;
    logic               neg;

    // 360<<k in a widened datapath so the shifted divisor never overflows.
    assign div_w  = {{ANGLE_W{1'b0}}, 9'(DEG_FULL)} << k_q;
    assign rem_w  = {9'd0, rem_q};
    assign diff_w = rem_w - div_w;

    always_comb begin
        r        = rem_q[8:0];
        c        = r;
        neg      = 1'b0;
        rom_addr = 7'd0;
        if (sin_q) c = (r >= 9'd90) ? r - 9'd90 : r + 9'd270;
        unique case (1'b1)
            (c < 9'd90): begin
                rom_addr = 7'(c);
            end
            (c >= 9'd90 && c < 9'd180): begin
                rom_addr = 7'(9'd180 - c);
                neg      = 1'b1;
            end
            (c >= 9'd180 && c < 9'd270): begin
                rom_addr = 7'(c - 9'd180);
                neg      = 1'b1;
            end
            (c >= 9'd270 && c < 9'd360): begin
                rom_addr = 7'(9'd360 - c);
            end
            default: rom_addr = 7'd0;
        endcase
    end

    cos_rom_q1 u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        k_d         = k_q;
        sin_d       = sin_q;
        tag_d       = tag_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = in_angle;
                    sin_d   = in_sin;
                    tag_d   = in_tag;
                    k_d     = K_TOP;
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (rem_w >= div_w) rem_d = diff_w[ANGLE_W-1:0];
                if (k_q == '0) state_d = ST_LOOKUP;
                else           k_d     = k_q - KW'(1);
            end
            ST_LOOKUP: begin
                // A zero magnitude is always +0.0, never -0.0.
                out_data_d  = (rom_data == '0) ? '0
                            : {neg, rom_data[RES_W-2:0]};
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            sin_q       <= 1'b0;
            tag_q       <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            sin_q       <= sin_d;
            tag_q       <= tag_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_trig_lut_unit.sv
// Scoreboard bench for trig_lut_unit: directed corner angles, hold/reset
// scenarios and randomized angles against a real-arithmetic trig model.
module tb_trig_lut_unit;

    localparam int AW  = 32;
    localparam int TW  = 4;
    localparam int LAT = AW - 7;
    localparam real PI = 3.141592653589793;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_angle = '0;
    logic          in_sin = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    trig_lut_unit #(.ANGLE_W(AW), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .in_sin    (in_sin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [63:0]   exp;
        logic          exact;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    logic rdy_man = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // cos of m degrees, 0..90, picking the well-conditioned formula
    function automatic real cos_q1(int m);
        if (m == 90) return 0.0;
        if (m > 45) return $sin(real'(90 - m) * PI / 180.0);
        return $cos(real'(m) * PI / 180.0);
    endfunction

    function automatic logic [63:0] ref_trig(logic [AW-1:0] a, logic s);
        int  r, d;
        real v;
        r = int'(a % 360);
        d = s ? 90 - r : r;
        d = (d + 360) % 360;
        if (d > 180) d = 360 - d;
        v = (d > 90) ? -cos_q1(180 - d) : cos_q1(d);
        if (v == 0.0) return 64'h0;
        return $realtobits(v);
    endfunction

    function automatic logic close(logic [63:0] a, logic [63:0] e, logic exact);
        longint d;
        if (e == 64'h0 || exact) return a == e;
        if (a[63] != e[63]) return 1'b0;
        d = longint'({1'b0, a[62:0]}) - longint'({1'b0, e[62:0]});
        if (d < 0) d = -d;
        return d <= 4;
    endfunction

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: drives out_ready and pops/compares on each handshake.
    logic          prev_v = 1'b0;
    logic [63:0]   prev_d = '0;
    logic [TW-1:0] prev_t = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                    out_ready = rdy_man;
        if (reset) begin
            prev_v = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1'b0, out_data, 64'h0);
            end else begin
                e = sb[0];
                if (!prev_v) begin
                    check("latency", (cyc - e.acc) == LAT,
                          64'(cyc - e.acc), 64'(LAT));
                end else begin
                    check("hold_data", out_data == prev_d, out_data, prev_d);
                    check("hold_tag", out_tag == prev_t, 64'(out_tag), 64'(prev_t));
                end
                if (out_ready) begin
                    check("data", close(out_data, e.exp, e.exact), out_data, e.exp);
                    check("tag", out_tag == e.tag, 64'(out_tag), 64'(e.tag));
                    void'(sb.pop_front());
                end
            end
        end
        prev_v = out_valid && !reset;
        prev_d = out_data;
        prev_t = out_tag;
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [AW-1:0] a, input logic s,
                        input logic [TW-1:0] t, input logic exact,
                        input logic [63:0] xv, output int waited);
        exp_t e;
        in_valid = 1'b1;
        in_angle = a;
        in_sin   = s;
        in_tag   = t;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 200);
        if (!in_ready) begin
            check("accept_timeout", 1'b0, 64'(waited), 64'd0);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            e.exp   = exact ? xv : ref_trig(a, s);
            e.exact = exact;
            e.tag   = t;
            e.acc   = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", sb.size() == 0 && !out_valid,
              64'(sb.size()), 64'd0);
    endtask

    logic [AW-1:0] dir_a [12] = '{32'd0, 32'd90, 32'd270, 32'd180, 32'd420,
                                  32'd270, 32'hFFFF_FFFF, 32'd359, 32'd60,
                                  32'd0, 32'd180, 32'd90};
    logic          dir_s [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic          dir_x [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0]   dir_v [12] = '{64'h3FF0000000000000, 64'h0, 64'h0,
                                  64'hBFF0000000000000, 64'h3FEBB67AE8584CAA,
                                  64'hBFF0000000000000, 64'h0, 64'h0,
                                  64'h3FE0000000000000, 64'h0, 64'h0,
                                  64'h3FF0000000000000};

    initial begin
        int          w;
        int          n;
        logic        saw;
        logic [63:0] held;
        logic [AW-1:0] a;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
        check("rst_out_data", out_data == 64'h0, out_data, 64'h0);
        check("rst_out_tag", out_tag == '0, 64'(out_tag), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            send(dir_a[i], dir_s[i], (i == 0) ? TW'(3) : TW'(i),
                 dir_x[i], dir_v[i], w);
        end
        drain();

        // Stalled consumer, then release with a request already waiting.
        rdy_man  = 1'b0;
        rdy_mode = 2;
        send(32'd777, 1'b0, TW'(5), 1'b0, 64'h0, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_rise", out_valid == 1'b1, 64'(out_valid), 64'd1);
        held = out_data;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("stall_data", out_valid && out_data == held, out_data, held);
            check("stall_in_ready", in_ready == 1'b0, 64'(in_ready), 64'd0);
        end
        rdy_man = 1'b1;
        send(32'd45, 1'b1, TW'(6), 1'b0, 64'h0, w);
        check("release_accept_edges", w == 2, 64'(w), 64'd2);
        drain();
        rdy_mode = 0;

        // Reset while reducing abandons the request.
        send(32'd123456, 1'b0, TW'(7), 1'b0, 64'h0, w);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1'b1;
        end
        check("abandoned_no_output", saw == 1'b0, 64'(saw), 64'd0);
        send(32'd123456, 1'b0, TW'(8), 1'b0, 64'h0, w);
        drain();

        rdy_mode = 1;
        repeat (60) begin
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom)
                                            : AW'($urandom_range(0, 1500));
            send(a, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)),
                 1'b0, 64'h0, w);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
